nios_touch_event_queue: RTL and testbench
=========================================

NIOS_TOUCH_EVENT_QUEUE -- requirements
Module: nios_touch_event_queue

Interface
REQ-001 Parameter COORD_W, default 12, width of the X/Y coordinates; legal range 8..14.
REQ-002 Parameter FIFO_DEPTH, default 8, number of event-queue entries; power of two, 2..64.
REQ-003 Parameter CNT_W = log2(FIFO_DEPTH)+1, derived, width of the occupancy count.
REQ-004 Clock  input  1  single clock; all state changes on the rising edge.
REQ-005 Resetn  input  1  asynchronous, active-low reset.
REQ-006 Touch_En  input  1  panel touched (level).
REQ-007 Coord_En  input  1  one-cycle strobe; X_Coord/Y_Coord valid.
REQ-008 X_Coord, Y_Coord  input  COORD_W each  sampled coordinates.
REQ-009 address  input  3  Avalon-MM slave word address.
REQ-010 chipselect, read, write  input  1 each  Avalon-MM strobes.
REQ-011 writedata  input  32  write data.
REQ-012 readdata  output  32  registered read data.
REQ-013 irq  output  1  level interrupt request.

Function
REQ-014 Read latency is one cycle: readdata is loaded from the addressed register on every clock edge; a write has no side effects on readdata.
REQ-015 Register map:
- 0 EVENT (R, pop): {valid, type[1:0], 1'b0, X zero-extended to 14 bits at [27:14], Y zero-extended to 14 bits at [13:0]}.
- 1 LIMIT (R/W): 32-bit repeat period; reset 32'hFFFFFFFF.
- 2 STATUS (R): {count[CNT_W-1:0] at [15:8], 5'd0, lost, full, empty}. Write: bit0=1 clears lost; bit1=1 flushes the queue.
- 3 IRQCFG (R/W): [2:0] enables {lost, level, nonempty}; [15:8] threshold; reset 0.
- 4..7: read as 0; writes ignored.
REQ-016 Event types: 00 COORD, 01 PRESS, 10 RELEASE, 11 REPEAT. Every event carries the last latched X/Y.
REQ-017 Latched X/Y update on Coord_En regardless of Touch_En; both reset to 0.
REQ-018 PRESS is generated on a Touch_En 0->1 transition and RELEASE on a 1->0 transition. Transitions are detected against a registered copy of Touch_En.
REQ-019 COORD is generated on Coord_En while Touch_En=1. The COORD event carries the newly presented X/Y, not the previously latched values.
REQ-020 Repeat counter:
- Cleared to 0 while Touch_En=0.
- Armed after the first Coord_En of a touch.
- While armed, it reloads LIMIT when at 0 and otherwise decrements.
- A REPEAT event is generated on each reload except the first.
REQ-021 At most one push per cycle. Priority is RELEASE > PRESS > COORD > REPEAT; any losing event is discarded and sets lost.
REQ-022 A push when full (with no pop in the same cycle) is discarded and sets lost. A simultaneous push and pop when full both succeed and count is unchanged.
REQ-023 A pop occurs on chipselect&read&address==0 when not empty. The head is presented in readdata with valid=1 in the next cycle. A read when empty returns valid=0 with all other bits 0, and no state changes.
REQ-024 Read and write pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH. full = (count==FIFO_DEPTH); empty = (count==0).
REQ-025 Flush sets both pointers and count to 0 in the following cycle. It overrides any push or pop in the same cycle, and leaves lost unchanged.
REQ-026 irq = (en[0]&~empty) | (en[1]&(count>=threshold)) | (en[2]&lost). irq is registered, one cycle after the condition. A threshold of 0 with en[1]=1 holds irq asserted.

Reset
REQ-027 On Resetn=0, the following are forced immediately:
- readdata=0, irq=0, queue empty, lost=0.
- Repeat counter=0; Touch_En history=0; X/Y=0.
- LIMIT=32'hFFFFFFFF; IRQCFG=0.
REQ-028 Reset mid-operation discards all queued events; the first edge after release behaves as after power-up.

Verification
REQ-029 Touch_En 0->1, Coord_En with X=0x123, Y=0x456, then Touch_En 1->0; pop three times -> PRESS(0,0), COORD(0x123,0x456), RELEASE(0x123,0x456); a fourth pop returns 0x00000000.
REQ-030 LIMIT=3, hold touch with one Coord_En -> REPEAT every 4 cycles after arming; count increments by one per REPEAT.
REQ-031 Push FIFO_DEPTH+1 events without popping -> full=1, count=FIFO_DEPTH, lost=1. A push+pop cycle while full keeps count=FIFO_DEPTH with no further loss.
REQ-032 Coord_En in the same cycle as a Touch_En 0->1 transition -> only PRESS is queued and lost=1. A STATUS write of 0x1 clears lost.
REQ-033 IRQCFG threshold=2, en=010b; queue 2 events -> irq=1 one cycle later. Pop one -> irq=0. Flush -> count=0 and empty=1.
REQ-034 Assert Resetn=0 with 3 queued events and LIMIT=5 -> STATUS reads empty, LIMIT reads 0xFFFFFFFF, irq=0.

Source files
------------

// File: rtl/nios_touch_event_queue_if.sv
// Avalon-MM slave bus of the touch event queue, with one-cycle registered read data.
interface nios_touch_event_queue_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output read,
        output write,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  read,
        input  write,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/nios_touch_event_queue.sv
// Touch panel event queue for a Nios host: turns press/release/coordinate/repeat
// activity into FIFO events that are popped through an Avalon-MM register window.
module nios_touch_event_queue #(
    parameter int COORD_W    = 12,
    parameter int FIFO_DEPTH = 8
) (
    input  logic               Clock,
    input  logic               Resetn,
    input  logic               Touch_En,
    input  logic               Coord_En,
    input  logic [COORD_W-1:0] X_Coord,
    input  logic [COORD_W-1:0] Y_Coord,
    nios_touch_event_queue_if.slave bus,
    output logic               irq
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 2 + 2 * COORD_W;

    typedef enum logic [1:0] {
        EV_COORD   = 2'b00,
        EV_PRESS   = 2'b01,
        EV_RELEASE = 2'b10,
        EV_REPEAT  = 2'b11
    } ev_type_t;

    logic               touch_q;
    logic [COORD_W-1:0] x_lat;
    logic [COORD_W-1:0] y_lat;

    logic               rep_armed;
    logic               rep_seen;
    logic [31:0]        rep_cnt;

    logic [31:0]        limit_reg;
    logic [2:0]         irq_en;
    logic [7:0]         irq_thr;

    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               lost;
    logic [31:0]        readdata_q;

    logic               ev_press;
    logic               ev_release;
    logic               ev_coord;
    logic               ev_repeat;
    logic               push_req;
    logic               collision;
    ev_type_t           push_type;
    logic [COORD_W-1:0] push_x;
    logic [COORD_W-1:0] push_y;

    logic               bus_wr;
    logic               bus_rd;
    logic               flush;
    logic               lost_clr;
    logic               empty;
    logic               full;
    logic               pop;
    logic               overflow;
    logic               do_push;
    logic               do_pop;

    logic [ENTRY_W-1:0] head;
    logic [1:0]         head_type;
    logic [COORD_W-1:0] head_x;
    logic [COORD_W-1:0] head_y;
    logic [7:0]         count_8;
    logic [31:0]        rd_next;

    assign ev_press   = Touch_En & ~touch_q;
    assign ev_release = ~Touch_En & touch_q;
    assign ev_coord   = Coord_En & Touch_En;
    assign ev_repeat  = rep_armed & rep_seen & Touch_En & (rep_cnt == 32'd0);
    assign push_req   = ev_press | ev_release | ev_coord | ev_repeat;
    // Press and release are mutually exclusive, so any other pairing means a loser.
    assign collision  = ((ev_press | ev_release) & (ev_coord | ev_repeat))
                      | (ev_coord & ev_repeat);

    always_comb begin
        push_type = EV_REPEAT;
        push_x    = x_lat;
        push_y    = y_lat;
        if (ev_release) begin
            push_type = EV_RELEASE;
        end else if (ev_press) begin
            push_type = EV_PRESS;
        end else if (ev_coord) begin
            push_type = EV_COORD;
            push_x    = X_Coord;
            push_y    = Y_Coord;
        end
    end

    assign bus_wr   = bus.chipselect & bus.write;
    assign bus_rd   = bus.chipselect & bus.read;
    assign flush    = bus_wr & (bus.address == 3'd2) & bus.writedata[1];
    assign lost_clr = bus_wr & (bus.address == 3'd2) & bus.writedata[0];

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign pop      = bus_rd & (bus.address == 3'd0) & ~empty;
    assign do_push  = push_req & (~full | pop) & ~flush;
    assign do_pop   = pop & ~flush;
    assign overflow = push_req & full & ~pop & ~flush;

    assign head      = mem[rd_ptr];
    assign head_type = head[ENTRY_W-1 -: 2];
    assign head_x    = head[2*COORD_W-1 -: COORD_W];
    assign head_y    = head[COORD_W-1:0];
    assign count_8   = 8'(count);

    // Register-map read mux; EVENT reads as all zeros when nothing is queued.
    always_comb begin
        rd_next = 32'd0;
        case (bus.address)
            3'd0: begin
                if (!empty) begin
                    rd_next = {1'b1, head_type, 1'b0, 14'(head_x), 14'(head_y)};
                end
            end
            3'd1: rd_next = limit_reg;
            3'd2: rd_next = {16'd0, count_8, 5'd0, lost, full, empty};
            3'd3: rd_next = {16'd0, irq_thr, 5'd0, irq_en};
            default: rd_next = 32'd0;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            touch_q <= 1'b0;
            x_lat   <= '0;
            y_lat   <= '0;
        end else begin
            touch_q <= Touch_En;
            if (Coord_En) begin
                x_lat <= X_Coord;
                y_lat <= Y_Coord;
            end
        end
    end

    // The first reload after arming only starts the period, so it raises no REPEAT.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            rep_armed <= 1'b0;
            rep_seen  <= 1'b0;
            rep_cnt   <= 32'd0;
        end else if (!Touch_En) begin
            rep_armed <= 1'b0;
            rep_seen  <= 1'b0;
            rep_cnt   <= 32'd0;
        end else begin
            if (ev_coord) begin
                rep_armed <= 1'b1;
            end
            if (rep_armed) begin
                if (rep_cnt == 32'd0) begin
                    rep_cnt  <= limit_reg;
                    rep_seen <= 1'b1;
                end else begin
                    rep_cnt <= rep_cnt - 32'd1;
                end
            end
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            limit_reg <= 32'hFFFF_FFFF;
            irq_en    <= 3'd0;
            irq_thr   <= 8'd0;
        end else if (bus_wr) begin
            if (bus.address == 3'd1) begin
                limit_reg <= bus.writedata;
            end
            if (bus.address == 3'd3) begin
                irq_en  <= bus.writedata[2:0];
                irq_thr <= bus.writedata[15:8];
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (do_push) begin
            mem[wr_ptr] <= {push_type, push_x, push_y};
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // A new loss in the same cycle as a clear request wins, so no loss goes unreported.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            lost <= 1'b0;
        end else begin
            lost <= (lost & ~lost_clr) | collision | overflow;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            readdata_q <= 32'd0;
            irq        <= 1'b0;
        end else begin
            readdata_q <= rd_next;
            irq        <= (irq_en[0] & ~empty)
                        | (irq_en[1] & (count_8 >= irq_thr))
                        | (irq_en[2] & lost);
        end
    end

    assign bus.readdata = readdata_q;

endmodule

// File: tb/tb_nios_touch_event_queue.sv
// Directed, table-driven bench for the touch event queue; each vector is one bus cycle
// whose read data and irq are compared on the following falling edge.
module tb_nios_touch_event_queue;

    localparam logic [1:0] OP_IDLE  = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;

    logic        clock    = 1'b0;
    logic        resetn   = 1'b0;
    logic        touch_en = 1'b0;
    logic        coord_en = 1'b0;
    logic [11:0] x_coord  = 12'd0;
    logic [11:0] y_coord  = 12'd0;
    logic        irq;

    nios_touch_event_queue_if bus();

    nios_touch_event_queue #(
        .COORD_W    (12),
        .FIFO_DEPTH (8)
    ) dut (
        .Clock    (clock),
        .Resetn   (resetn),
        .Touch_En (touch_en),
        .Coord_En (coord_en),
        .X_Coord  (x_coord),
        .Y_Coord  (y_coord),
        .bus      (bus),
        .irq      (irq)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        touch;
        logic        coord;
        logic [11:0] x;
        logic [11:0] y;
        logic [1:0]  op;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic [31:0] mask;
        logic        chk_irq;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[$];
    int   n_vectors     = 0;
    int   n_miscompares = 0;

    function automatic vec_t v_base(input logic t);
        vec_t v;
        v.touch   = t;
        v.coord   = 1'b0;
        v.x       = 12'd0;
        v.y       = 12'd0;
        v.op      = OP_IDLE;
        v.addr    = 3'd0;
        v.wdata   = 32'd0;
        v.chk_rd  = 1'b0;
        v.exp_rd  = 32'd0;
        v.mask    = 32'hFFFF_FFFF;
        v.chk_irq = 1'b0;
        v.exp_irq = 1'b0;
        return v;
    endfunction

    function automatic vec_t v_idle(input logic t, input logic ci, input logic ei);
        vec_t v;
        v         = v_base(t);
        v.chk_irq = ci;
        v.exp_irq = ei;
        return v;
    endfunction

    function automatic vec_t v_rd(input logic t, input logic [2:0] a, input logic [31:0] e,
                                  input logic ci, input logic ei);
        vec_t v;
        v         = v_base(t);
        v.op      = OP_READ;
        v.addr    = a;
        v.chk_rd  = 1'b1;
        v.exp_rd  = e;
        v.chk_irq = ci;
        v.exp_irq = ei;
        return v;
    endfunction

    function automatic vec_t v_wr(input logic t, input logic [2:0] a, input logic [31:0] d,
                                  input logic ci, input logic ei);
        vec_t v;
        v         = v_base(t);
        v.op      = OP_WRITE;
        v.addr    = a;
        v.wdata   = d;
        v.chk_irq = ci;
        v.exp_irq = ei;
        return v;
    endfunction

    function automatic vec_t v_coord(input logic t, input logic [11:0] x, input logic [11:0] y);
        vec_t v;
        v       = v_base(t);
        v.coord = 1'b1;
        v.x     = x;
        v.y     = y;
        return v;
    endfunction

    // Queue depth seen j edges after arming with LIMIT=3: PRESS+COORD, then one REPEAT per 4 edges from edge 5.
    function automatic logic [31:0] rep_status(input int j);
        int c;
        c = (j < 5) ? 2 : 2 + (j - 1) / 4;
        return 32'(c) << 8;
    endfunction

    task automatic checkOutput(input string what, input logic [31:0] actual,
                               input logic [31:0] expected, input logic [31:0] mask);
        n_vectors++;
        if ((actual & mask) !== (expected & mask)) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h (mask %h)", what, actual, expected, mask);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input string tag);
        touch_en       = v.touch;
        coord_en       = v.coord;
        x_coord        = v.x;
        y_coord        = v.y;
        bus.chipselect = (v.op != OP_IDLE);
        bus.read       = (v.op == OP_READ);
        bus.write      = (v.op == OP_WRITE);
        bus.address    = v.addr;
        bus.writedata  = v.wdata;
        @(negedge clock);
        if (v.chk_rd) begin
            checkOutput({tag, " readdata"}, bus.readdata, v.exp_rd, v.mask);
        end
        if (v.chk_irq) begin
            checkOutput({tag, " irq"}, {31'd0, irq}, {31'd0, v.exp_irq}, 32'h1);
        end
        coord_en       = 1'b0;
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t tmp;
        bus.address    = 3'd0;
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.writedata  = 32'd0;
        repeat (3) @(negedge clock);
        resetn = 1'b1;

        // Reset values, reserved space, basic PRESS/COORD/RELEASE ordering.
        vecs.push_back(v_rd(0, 3'd2, 32'h0000_0001, 1, 0));
        vecs.push_back(v_rd(0, 3'd1, 32'hFFFF_FFFF, 0, 0));
        vecs.push_back(v_rd(0, 3'd3, 32'h0000_0000, 0, 0));
        vecs.push_back(v_wr(0, 3'd5, 32'hFFFF_FFFF, 0, 0));
        vecs.push_back(v_rd(0, 3'd5, 32'h0000_0000, 0, 0));
        vecs.push_back(v_idle(1, 0, 0));
        vecs.push_back(v_coord(1, 12'h123, 12'h456));
        vecs.push_back(v_idle(0, 0, 0));
        vecs.push_back(v_rd(0, 3'd2, 32'h0000_0300, 0, 0));
        vecs.push_back(v_rd(0, 3'd0, 32'hA000_0000, 0, 0));
        vecs.push_back(v_rd(0, 3'd0, 32'h8048_C456, 0, 0));
        vecs.push_back(v_rd(0, 3'd0, 32'hC048_C456, 0, 0));
        vecs.push_back(v_rd(0, 3'd0, 32'h0000_0000, 0, 0));
        vecs.push_back(v_rd(0, 3'd2, 32'h0000_0001, 0, 0));
        // Level interrupt at threshold 2, then flush.
        vecs.push_back(v_wr(0, 3'd3, 32'h0000_0202, 1, 0));
        vecs.push_back(v_rd(0, 3'd3, 32'h0000_0202, 1, 0));
        vecs.push_back(v_idle(1, 1, 0));
        vecs.push_back(v_idle(0, 1, 0));
        vecs.push_back(v_idle(0, 1, 1));
        vecs.push_back(v_rd(0, 3'd0, 32'hA048_C456, 1, 1));
        vecs.push_back(v_idle(0, 1, 0));
        vecs.push_back(v_wr(0, 3'd2, 32'h0000_0002, 1, 0));
        vecs.push_back(v_rd(0, 3'd2, 32'h0000_0001, 1, 0));
        // Coordinate strobe colliding with a press: only PRESS survives, lost is set.
        vecs.push_back(v_coord(1, 12'h0AA, 12'h055));
        vecs.push_back(v_rd(1, 3'd2, 32'h0000_0104, 0, 0));
        tmp      = v_rd(1, 3'd0, 32'hA000_0000, 0, 0);
        tmp.mask = 32'hF000_0000;
        vecs.push_back(tmp);
        vecs.push_back(v_wr(1, 3'd2, 32'h0000_0001, 0, 0));
        vecs.push_back(v_rd(1, 3'd2, 32'h0000_0001, 0, 0));
        vecs.push_back(v_idle(0, 0, 0));
        vecs.push_back(v_wr(0, 3'd2, 32'h0000_0002, 0, 0));
        vecs.push_back(v_rd(0, 3'd2, 32'h0000_0001, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Auto-repeat with LIMIT=3 while the touch is held.
        applyStimulus(v_wr(0, 3'd1, 32'd3, 0, 0), "rep limit");
        applyStimulus(v_idle(1, 0, 0), "rep press");
        applyStimulus(v_coord(1, 12'h010, 12'h020), "rep coord");
        for (int i = 1; i <= 18; i++) begin
            applyStimulus(v_rd(1, 3'd2, rep_status(i - 1), 0, 0), $sformatf("rep status%0d", i));
        end
        applyStimulus(v_rd(1, 3'd0, 32'hA02A_8055, 0, 0), "rep pop press");
        applyStimulus(v_rd(1, 3'd0, 32'h8004_0020, 0, 0), "rep pop coord");
        applyStimulus(v_rd(1, 3'd0, 32'hE004_0020, 0, 0), "rep pop repeat");
        applyStimulus(v_idle(0, 0, 0), "rep release");
        applyStimulus(v_wr(0, 3'd2, 32'h0000_0002, 0, 0), "rep flush");
        applyStimulus(v_rd(0, 3'd2, 32'h0000_0001, 0, 0), "rep empty");

        // Overflow: nine pushes into eight entries, then push+pop while full.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(v_idle((i % 2) == 0, 0, 0), $sformatf("ovf push%0d", i));
        end
        applyStimulus(v_rd(1, 3'd2, 32'h0000_0806, 0, 0), "ovf status");
        applyStimulus(v_wr(1, 3'd2, 32'h0000_0001, 0, 0), "ovf clear");
        applyStimulus(v_rd(0, 3'd0, 32'hA004_0020, 1, 1), "ovf push+pop");
        applyStimulus(v_rd(0, 3'd2, 32'h0000_0802, 0, 0), "ovf full kept");
        applyStimulus(v_idle(1, 0, 0), "ovf drop");
        applyStimulus(v_rd(1, 3'd2, 32'h0000_0806, 0, 0), "ovf lost again");

        // Reset in the middle of activity.
        applyStimulus(v_wr(1, 3'd2, 32'h0000_0002, 0, 0), "rst flush");
        applyStimulus(v_idle(0, 0, 0), "rst ev1");
        applyStimulus(v_idle(1, 0, 0), "rst ev2");
        applyStimulus(v_idle(0, 0, 0), "rst ev3");
        applyStimulus(v_wr(0, 3'd1, 32'd5, 0, 0), "rst limit");
        applyStimulus(v_wr(0, 3'd3, 32'h0000_0001, 0, 0), "rst irqcfg");
        applyStimulus(v_rd(0, 3'd1, 32'd5, 1, 1), "rst pre");
        resetn = 1'b0;
        #1;
        checkOutput("rst async readdata", bus.readdata, 32'd0, 32'hFFFF_FFFF);
        checkOutput("rst async irq", {31'd0, irq}, 32'd0, 32'h1);
        @(negedge clock);
        resetn = 1'b1;
        applyStimulus(v_rd(0, 3'd2, 32'h0000_0001, 1, 0), "rst status");
        applyStimulus(v_rd(0, 3'd1, 32'hFFFF_FFFF, 0, 0), "rst limit rd");
        applyStimulus(v_rd(0, 3'd3, 32'h0000_0000, 0, 0), "rst irqcfg rd");
        applyStimulus(v_rd(0, 3'd0, 32'h0000_0000, 0, 0), "rst event rd");

        // Threshold 0 with the level enable holds irq high on an empty queue.
        applyStimulus(v_wr(0, 3'd3, 32'h0000_0002, 0, 0), "thr0 cfg");
        applyStimulus(v_idle(0, 1, 1), "thr0 irq");
        applyStimulus(v_wr(0, 3'd3, 32'h0000_0000, 1, 1), "thr0 off");
        applyStimulus(v_idle(0, 1, 0), "thr0 irq off");

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
